// File: rtl/ahfp_pkg.sv
// ahfp_pkg: shared widths and IEEE-style field helpers for the ahfp FP datapath.
// Helpers take the field widths as arguments and work on words up to 64 bits.
// Optional feature macro used by this datapath: AHFP_ADDSUB_SPECIAL_EN.
package ahfp_pkg;

  localparam int unsigned DEF_EXP_W = 8;
  localparam int unsigned DEF_MAN_W = 23;
  localparam int unsigned W         = 1 + DEF_EXP_W + DEF_MAN_W;
  localparam int unsigned SIG_W     = DEF_MAN_W + 1;
  localparam int unsigned GRS_W     = 3;

  function automatic logic sign_of(logic [63:0] w, int unsigned exp_w, int unsigned man_w);
    return 1'((w >> (exp_w + man_w)) & 64'd1);
  endfunction

  function automatic logic [63:0] exp_of(logic [63:0] w, int unsigned exp_w,
                                         int unsigned man_w);
    return (w >> man_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] man_of(logic [63:0] w, int unsigned man_w);
    return w & ((64'd1 << man_w) - 64'd1);
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
  function automatic logic [63:0] qnan_word(int unsigned exp_w, int unsigned man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] inf_word(int unsigned exp_w, int unsigned man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  // Largest finite magnitude: exponent all ones minus one, mantissa all ones.
  function automatic logic [63:0] max_finite_word(int unsigned exp_w, int unsigned man_w);
    return (((64'd1 << exp_w) - 64'd2) << man_w) | ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/ahfp_lzc.sv
// ahfp_lzc: combinational leading-zero counter; all-zero input returns WIDTH.
module ahfp_lzc #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] count
);

  // Scan upward so the most significant set bit has the final say.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/ahfp_addsub_pipe.sv
// ahfp_addsub_pipe: pipelined FP add/sub with valid/ready flow control and a tag.
// Operand capture, align, add and normalise/round registers give 3-edge latency.
// Define AHFP_ADDSUB_SPECIAL_EN for Inf/NaN handling and overflow to Inf; otherwise
// all-ones exponents are ordinary and overflow saturates to max finite.
module ahfp_addsub_pipe
  import ahfp_pkg::*;
#(
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op_sub,
  input  logic [EXP_W+MAN_W:0] dataa,
  input  logic [EXP_W+MAN_W:0] datab,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int unsigned WORD_W = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_N  = MAN_W + 1;
  localparam int unsigned EXT_W  = SIG_N + GRS_W;      // significand plus guard/round/sticky
  localparam int unsigned SUM_W  = EXT_W + 1;          // plus carry
  localparam int unsigned LZC_W  = $clog2(EXT_W + 1);
  localparam int unsigned EW     = EXP_W + 2;          // signed exponent with headroom
  localparam logic [WORD_W-1:0] QNAN = WORD_W'(qnan_word(EXP_W, MAN_W));
  localparam logic [WORD_W-1:0] INF  = WORD_W'(inf_word(EXP_W, MAN_W));
`ifndef AHFP_ADDSUB_SPECIAL_EN
  localparam logic [WORD_W-1:0] MAXF = WORD_W'(max_finite_word(EXP_W, MAN_W));
`endif

  logic advance;

  logic                v0_q, sub0_q;
  logic [WORD_W-1:0]   a0_q, b0_q;
  logic [TAG_W-1:0]    tag0_q, tag1_q, tag2_q;
  logic                v1_q, sign1_q, effsub1_q, nan1_q, inf1_q, infs1_q;
  logic [EXP_W-1:0]    exp1_q, exp2_q;
  logic [EXT_W-1:0]    big1_q, small1_q;
  logic                v2_q, sign2_q, effsub2_q, nan2_q, inf2_q, infs2_q;
  logic [SUM_W-1:0]    sum2_q;

  logic                sa, sb, swap, sign1_d, effsub1_d, nan1_d, inf1_d, infs1_d;
  logic [EXP_W-1:0]    ea, eb, exp1_d, exp_diff;
  logic [MAN_W-1:0]    ma, mb;
  logic [SIG_N-1:0]    siga, sigb, sig_big, sig_small;
  logic [EXT_W-1:0]    big1_d, small1_d, small_ext, lost_mask;
  logic [SUM_W-1:0]    sum2_d;

  logic                carry, round_up;
  logic [LZC_W-1:0]    lz;
  logic [EXT_W-1:0]    norm;
  logic [EW-1:0]       exp_n, exp_f;
  logic [SIG_N:0]      rounded;
  logic [WORD_W-1:0]   result_d;

  // A single global stall: every stage moves only when the output slot frees up.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1: unpack, order operands by magnitude and align the smaller one.
  always_comb begin
    sa   = sign_of(64'(a0_q), EXP_W, MAN_W);
    sb   = sign_of(64'(b0_q), EXP_W, MAN_W) ^ sub0_q;
    ea   = EXP_W'(exp_of(64'(a0_q), EXP_W, MAN_W));
    eb   = EXP_W'(exp_of(64'(b0_q), EXP_W, MAN_W));
    ma   = MAN_W'(man_of(64'(a0_q), MAN_W));
    mb   = MAN_W'(man_of(64'(b0_q), MAN_W));
    siga = (ea != '0) ? {1'b1, ma} : '0;  // zero exponent flushes to zero
    sigb = (eb != '0) ? {1'b1, mb} : '0;
    swap      = {eb, sigb} > {ea, siga};
    sign1_d   = swap ? sb : sa;
    exp1_d    = swap ? eb : ea;
    sig_big   = swap ? sigb : siga;
    sig_small = swap ? siga : sigb;
    exp_diff  = swap ? (eb - ea) : (ea - eb);
    effsub1_d = sa ^ sb;
    big1_d    = {sig_big, {GRS_W{1'b0}}};
    small_ext = {sig_small, {GRS_W{1'b0}}};
    lost_mask = ~({EXT_W{1'b1}} << exp_diff);
    if (32'(exp_diff) >= MAN_W + GRS_W) begin
      small1_d = {{(EXT_W-1){1'b0}}, |sig_small};
    end else begin
      small1_d = (small_ext >> exp_diff) | {{(EXT_W-1){1'b0}}, |(small_ext & lost_mask)};
    end
`ifdef AHFP_ADDSUB_SPECIAL_EN
    nan1_d  = (&ea && ma != '0) || (&eb && mb != '0)
           || (&ea && ma == '0 && &eb && mb == '0 && (sa ^ sb));
    inf1_d  = ((&ea && ma == '0) || (&eb && mb == '0)) && !nan1_d;
    infs1_d = (&ea && ma == '0) ? sa : sb;
`else
    nan1_d  = 1'b0;
    inf1_d  = 1'b0;
    infs1_d = 1'b0;
`endif
  end

  // Stage 2: magnitude add/subtract; big >= small so the difference is never negative.
  always_comb begin
    if (effsub1_q) sum2_d = {1'b0, big1_q} - {1'b0, small1_q};
    else           sum2_d = {1'b0, big1_q} + {1'b0, small1_q};
  end

  ahfp_lzc #(
    .WIDTH(EXT_W),
    .CNT_W(LZC_W)
  ) u_lzc (
    .value(sum2_q[EXT_W-1:0]),
    .count(lz)
  );

  // Stage 3: normalise, round to nearest even, then resolve zero/under/overflow/specials.
  always_comb begin
    carry = sum2_q[SUM_W-1];
    if (carry) begin
      norm  = {sum2_q[SUM_W-1:2], |sum2_q[1:0]};
      exp_n = {2'b00, exp2_q} + EW'(1);
    end else begin
      norm  = sum2_q[EXT_W-1:0] << lz;
      exp_n = {2'b00, exp2_q} - EW'(lz);
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[EXT_W-1:GRS_W]} + (SIG_N+1)'(round_up);
    exp_f    = exp_n + EW'(rounded[SIG_N]);
    result_d = {sign2_q, exp_f[EXP_W-1:0], rounded[MAN_W-1:0]};
    if (sum2_q == '0) begin
      // Exact cancellation is +0; only same-sign zero operands keep their sign.
      result_d = {sign2_q & ~effsub2_q, {(WORD_W-1){1'b0}}};
    end else if (exp_f[EW-1] || exp_f == '0) begin
      result_d = {sign2_q, {(WORD_W-1){1'b0}}};
    end else if (exp_f >= EW'((1 << EXP_W) - 1)) begin
`ifdef AHFP_ADDSUB_SPECIAL_EN
      result_d = {sign2_q, INF[WORD_W-2:0]};
`else
      result_d = {sign2_q, MAXF[WORD_W-2:0]};
`endif
    end
    if (nan2_q)      result_d = QNAN;
    else if (inf2_q) result_d = {infs2_q, INF[WORD_W-2:0]};
  end

  // Control state: stage valids and the output register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
    end else if (advance) begin
      v0_q      <= in_valid;
      v1_q      <= v0_q;
      v2_q      <= v1_q;
      out_valid <= v2_q;
      if (v2_q) begin
        result  <= result_d;
        out_tag <= tag2_q;
      end
    end
  end

  // Datapath registers; bubbles carry don't-care payload so no reset is needed.
  always_ff @(posedge clk) begin
    if (advance) begin
      a0_q      <= dataa;
      b0_q      <= datab;
      sub0_q    <= op_sub;
      tag0_q    <= in_tag;
      sign1_q   <= sign1_d;
      effsub1_q <= effsub1_d;
      exp1_q    <= exp1_d;
      big1_q    <= big1_d;
      small1_q  <= small1_d;
      nan1_q    <= nan1_d;
      inf1_q    <= inf1_d;
      infs1_q   <= infs1_d;
      tag1_q    <= tag0_q;
      sign2_q   <= sign1_q;
      effsub2_q <= effsub1_q;
      exp2_q    <= exp1_q;
      sum2_q    <= sum2_d;
      nan2_q    <= nan1_q;
      inf2_q    <= inf1_q;
      infs2_q   <= infs1_q;
      tag2_q    <= tag1_q;
    end
  end

endmodule

// File: doc/ahfp_addsub_pipe.md
Name: ahfp_addsub_pipe

Overview:
- Parametrised, pipelined floating-point adder/subtractor. Successor to the combinational single-precision ahfp_add.
- Adds run-time add/sub mode, configurable exponent/mantissa widths, valid/ready flow control with back-pressure, and a pass-through tag.
- Sits between operand sourcing logic and the result consumer in the FP datapath.
- Fixed latency of 3 accepted-beat stages.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width; word width W = 1+EXP_W+MAN_W.
- TAG_W, 4, width of the user tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- op_sub  in  1  0: dataa+datab; 1: dataa-datab.
- dataa  in  W  operand A (sign|exp|man).
- datab  in  W  operand B.
- in_tag  in  TAG_W  user tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  W  rounded sum/difference.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset: out_valid=0, result=0, out_tag=0, and all internal stage-valid bits=0. Reset mid-operation discards every in-flight beat. in_ready=1 from the first cycle after reset.
- Handshake: a beat transfers when valid&&ready on the same edge.
  - Global stall: advance = !out_valid || out_ready; in_ready = advance.
  - When advance=0, all stages hold their contents.
  - result and out_tag remain stable while out_valid && !out_ready.
- Latency: a beat accepted at edge N gives out_valid=1 after edge N+3, provided no stall occurs. Back-to-back beats give 1 result per cycle.
- Stage 1 (align):
  - Effective B sign = sign_b ^ op_sub.
  - Swap so the larger magnitude (by exp, then mantissa) is A.
  - Restore the hidden bit for exp!=0. exp==0 is treated as zero (denormals flushed to zero).
  - Shift B's significand right by expA-expB, keeping guard, round and sticky bits. A shift >= MAN_W+3 gives sticky only.
- Stage 2 (add): add or subtract significands (MAN_W+4 bits plus carry). Register the raw sum, the large exponent and the result sign.
- Stage 3 (normalise/round):
  - Carry-out: shift right 1 and exp+1.
  - Otherwise: left shift by the leading-zero count and exp-=lzc.
  - Rounding is round-to-nearest-even.
  - A rounding carry renormalises (exp+1).
- Zero result: exact zero gives +0 (0x00000000 at default widths), except (-0)+(-0) gives -0.
- Underflow: exp<=0 after normalisation flushes to signed zero.
- Overflow: exp >= 2^EXP_W-1 is handled per the Optional Feature.
- Simultaneous events: acceptance of a new beat and draining of the output in the same cycle is legal and loses no data.

Optional Feature:
- Macro: AHFP_ADDSUB_SPECIAL_EN.
- Defined:
  - Operands with exp all-ones are IEEE Inf/NaN.
  - Inf±finite gives Inf. Inf-Inf (effective) gives canonical qNaN (sign 0, exp all-ones, man MSB=1). Any NaN input gives canonical qNaN.
  - Overflow gives signed Inf.
- Undefined:
  - exp all-ones is treated as an ordinary exponent.
  - Overflow saturates to signed max finite (0x7F7FFFFF / 0xFF7FFFFF at default widths).

Decomposition:
- Package ahfp_pkg holds:
  - width-derived localparams (W, SIG_W=MAN_W+1, GRS_W=3);
  - field-extract functions (sign/exp/man);
  - the canonical qNaN and max-finite constants as functions of EXP_W/MAN_W.
- One sub-module, ahfp_lzc: parametrised combinational leading-zero counter used by stage 3.

Test Plan:
- Basic sub, no stalls, out_ready=1: (3F800000 - 40000000) gives BF800000 at accept+3. (43FA0000 - 41133333) gives 43F56666.
- Add mode: 40400000 + 40600000 gives 40D00000. 3F800000 - 3F800000 gives 00000000.
- Rounding: 3F800000 + 33800000 (tie) gives 3F800000. 3F800001 + 33800000 gives 3F800002.
- Back-pressure:
  - Stimulus: stream 4 beats with tags 1..4 and hold out_ready=0 for 5 cycles.
  - Required: in_ready drops; result/out_tag are stable throughout the stall; then tags 1,2,3,4 emerge in order with no loss or duplication.
- Overflow: 7F7FFFFF + 7F7FFFFF gives 7F800000 with AHFP_ADDSUB_SPECIAL_EN and 7F7FFFFF without it. With the macro, 7F800000 - 7F800000 gives 7FC00000.
- Reset mid-flight: assert rst for 1 cycle with 2 beats in flight. out_valid=0 on the next cycle and neither result ever appears. A new beat 40000000 - 40800000 then gives C0000000 at accept+3.
